// File: rtl/rx_channel_buf_if.sv
// Upstream VALID/READY bus between a transmitter (master) and rx_channel_buf (slave).
interface rx_channel_buf_if #(
    parameter int WIDTH = 8
);
    logic             VALID;
    logic             READY;
    logic [WIDTH-1:0] xDATA;

    modport master (
        output VALID,
        output xDATA,
        input  READY
    );

    modport slave (
        input  VALID,
        input  xDATA,
        output READY
    );
endinterface

// File: rtl/rx_channel_buf.sv
// First-word fall-through receive buffer with a registered READY and a sticky
// flag for upstream handshake violations (VALID dropped or data changed while stalled).
module rx_channel_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    rx_channel_buf_if.slave          bus,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic             err_q, err_d;
    logic             push, pop;

    always_comb begin
        push        = bus.VALID & ready_q;
        pop         = (count_q != '0) & rx_pop;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // READY is a flop computed from next occupancy, so it never sees VALID combinationally.
        ready_d     = (count_d < FULL);
        pend_d      = bus.VALID & ~ready_q;
        pend_data_d = bus.xDATA;
        err_d       = err_q | (pend_q & (~bus.VALID | (bus.xDATA != pend_data_q)));
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            err_q       <= err_d;
        end
    end

    // Storage is deliberately unreset; rx_data is only meaningful while rx_valid=1.
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.xDATA;
    end

    assign bus.READY = ready_q;
    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign proto_err = err_q;
endmodule

// File: tb/tb_rx_channel_buf.sv
// Directed vector table plus hand-written multi-cycle sequences for rx_channel_buf (WIDTH=8, DEPTH=4).
module tb_rx_channel_buf;
    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic [2:0] count;
    logic       proto_err;

    int total = 0;
    int bad   = 0;

    rx_channel_buf_if #(.WIDTH(8)) bus ();

    rx_channel_buf #(.WIDTH(8), .DEPTH(4)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .bus       (bus),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .count     (count),
        .proto_err (proto_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       pop;
        logic       e_ready;
        logic       e_rxv;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic pop);
        bus.VALID = v;
        bus.xDATA = d;
        rx_pop    = pop;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic rxv,
                           input logic [7:0] data, input logic [2:0] cnt, input logic err);
        chk({tag, ".READY"}, 32'(bus.READY), 32'(rdy));
        chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(rxv));
        if (rxv) chk({tag, ".rx_data"}, 32'(rx_data), 32'(data));
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(err));
    endtask

    function automatic vec_t mk(logic v, logic [7:0] d, logic pop, logic rdy, logic rxv,
                                logic [7:0] data, logic [2:0] cnt, logic err);
        vec_t r;
        r.v = v; r.d = d; r.pop = pop; r.e_ready = rdy; r.e_rxv = rxv;
        r.e_data = data; r.e_cnt = cnt; r.e_err = err;
        return r;
    endfunction

    initial begin
        //                v  xDATA  pop  READY rxv  data   cnt  err
        tbl.push_back(mk(1, 8'hA5, 0,   1,    0,   8'h00, 0,   0)); // first edge after reset: READY rises
        tbl.push_back(mk(1, 8'hA5, 0,   1,    1,   8'hA5, 1,   0)); // push A5, visible next cycle
        tbl.push_back(mk(0, 8'h00, 1,   1,    0,   8'h00, 0,   0));
        tbl.push_back(mk(1, 8'h01, 0,   1,    1,   8'h01, 1,   0));
        tbl.push_back(mk(1, 8'h02, 0,   1,    1,   8'h01, 2,   0));
        tbl.push_back(mk(1, 8'h03, 0,   1,    1,   8'h01, 3,   0));
        tbl.push_back(mk(1, 8'h04, 0,   0,    1,   8'h01, 4,   0)); // full
        tbl.push_back(mk(1, 8'h05, 0,   0,    1,   8'h01, 4,   0)); // 05 held
        tbl.push_back(mk(1, 8'h05, 1,   1,    1,   8'h02, 3,   0)); // pop while full
        tbl.push_back(mk(1, 8'h05, 0,   0,    1,   8'h02, 4,   0)); // 05 accepted
        tbl.push_back(mk(0, 8'h00, 1,   1,    1,   8'h03, 3,   0));
        tbl.push_back(mk(0, 8'h00, 1,   1,    1,   8'h04, 2,   0));
        tbl.push_back(mk(0, 8'h00, 1,   1,    1,   8'h05, 1,   0));
        tbl.push_back(mk(0, 8'h00, 1,   1,    0,   8'h00, 0,   0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0));   // pop on empty: no effect
        tbl.push_back(mk(1, 8'h77, 1,   1,    1,   8'h77, 1,   0)); // empty push+pop: push only
        tbl.push_back(mk(1, 8'h78, 1,   1,    1,   8'h78, 1,   0)); // partial push+pop
        tbl.push_back(mk(0, 8'h00, 1,   1,    0,   8'h00, 0,   0));

        bus.VALID = 1'b0;
        bus.xDATA = '0;
        rx_pop    = 1'b0;
        #12;
        chk_out("reset", 0, 0, 8'h00, 0, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].pop);
            chk_out($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_rxv,
                    tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_err);
        end

        // Streaming: 20 beats with VALID and rx_pop both held high.
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(i), 1);
            chk($sformatf("stream%0d.rx_data", i), 32'(rx_data), 32'(i));
            chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
        end
        step(0, 8'h00, 1);
        chk_out("stream_drain", 1, 0, 8'h00, 0, 0);

        // Stall violation: fill, stall with 0x14 pending, then drop VALID.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0);
        chk_out("err_fill", 0, 1, 8'h10, 4, 0);
        step(1, 8'h14, 0);
        chk_out("err_pending", 0, 1, 8'h10, 4, 0);
        step(0, 8'h00, 0);
        chk_out("err_set", 0, 1, 8'h10, 4, 1);
        step(0, 8'h00, 1);
        chk_out("err_hold1", 1, 1, 8'h11, 3, 1);
        step(0, 8'h00, 1);
        chk_out("err_hold2", 1, 1, 8'h12, 2, 1);
        step(1, 8'h55, 1);
        chk_out("err_hold3", 1, 1, 8'h13, 2, 1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk_out("err_reset", 0, 0, 8'h00, 0, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Mid-cycle asynchronous reset with three words buffered.
        step(0, 8'h00, 0);
        chk_out("rel", 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'hB0 + i), 0);
        chk_out("three", 1, 1, 8'hB0, 3, 0);
        bus.VALID = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 8'h00, 0, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        step(0, 8'h00, 1);
        chk_out("after_rst", 1, 0, 8'h00, 0, 0);
        step(1, 8'hC0, 0);
        chk_out("post_push", 1, 1, 8'hC0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_channel_buf.md
RX_CHANNEL_BUF -- requirements
Module: rx_channel_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of 2, >= 2.
REQ-003 SHALL have port ACLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port VALID  input  1  bus VALID from the upstream transmitter.
REQ-006 SHALL have port READY  output  1  bus READY to the upstream transmitter.
REQ-007 SHALL have port xDATA  input  WIDTH  bus data, qualified by VALID.
REQ-008 SHALL have port rx_data  output  WIDTH  oldest buffered word (first-word fall-through).
REQ-009 SHALL have port rx_valid  output  1  rx_data holds a valid word.
REQ-010 SHALL have port rx_pop  input  1  consumer takes rx_data this cycle.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port proto_err  output  1  sticky upstream handshake violation.

Function
REQ-013 SHALL accept a beat (push) on a rising edge where VALID=1 and READY=1, writing xDATA at the write pointer.
REQ-014 SHALL retire a word (pop) on a rising edge where rx_valid=1 and rx_pop=1; rx_pop while rx_valid=0 SHALL have no effect.
REQ-015 SHALL drive READY from a register: READY(next) = (count_next < DEPTH); READY SHALL NOT depend combinationally on VALID.
REQ-016 SHALL drive rx_valid = (count != 0), and rx_data = mem[rd_ptr] whenever rx_valid=1.
REQ-017 SHALL give push-to-rx_valid latency of exactly 1 cycle when the buffer is empty.
REQ-018 SHALL update count as +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL wrap write and read pointers modulo DEPTH with no gap or duplicate entry.
REQ-020 SHALL preserve FIFO order: words leave in acceptance order.
REQ-021 Full (count=DEPTH): READY=0 from the cycle after the filling push; a pop while full SHALL raise READY on the next cycle.
REQ-022 Empty with simultaneous VALID and rx_pop: push SHALL occur and the pop SHALL be ignored; count becomes 1.
REQ-023 Partial occupancy with simultaneous push and pop: both SHALL occur and count SHALL stay unchanged.
REQ-024 SHALL track a pending state: VALID=1 and READY=0 at a rising edge, with the xDATA value captured.
REQ-025 When pending, the next edge with VALID=0, or with xDATA differing from the captured value, SHALL set proto_err=1; proto_err SHALL hold until reset.
REQ-026 proto_err SHALL NOT affect data flow.

Reset
REQ-027 While ARESETn=0: READY=0, rx_valid=0, count=0, proto_err=0, pointers=0, pending cleared.
REQ-028 First rising edge after ARESETn deasserts SHALL set READY=1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words immediately (asynchronous), with no pop observable afterwards.
REQ-030 Buffer memory contents need no reset; rx_data is don't-care while rx_valid=0.

Verification
REQ-031 Reset release, VALID=1, xDATA=0xA5, rx_pop=0 -> READY=1 after first edge, push on the next edge, rx_valid=1 and rx_data=0xA5 one cycle later, count=1.
REQ-032 DEPTH=4: push 0x01..0x04 with rx_pop=0, then VALID=1 xDATA=0x05 -> count=4, READY=0, 0x05 held; one pop -> rx_data 0x01 retired, READY=1 next cycle, 0x05 accepted, count=4.
REQ-033 Continuous VALID and rx_pop=1 for 20 beats, data 0x00..0x13 -> output sequence 0x00..0x13 in order, count stays 1 after fill, pointers wrap 5 times.
REQ-034 Fill to 4, then drop VALID while READY=0 -> proto_err=1 next cycle and stays 1 through later traffic until ARESETn=0.
REQ-035 Three words buffered, ARESETn pulsed low mid-cycle -> rx_valid=0, count=0, READY=0 immediately; READY=1 one edge after release.
REQ-036 Empty buffer, rx_pop=1 with VALID=0 for 5 cycles -> count stays 0, rx_valid=0, no pointer movement.
